// File: rtl/heading_pid.sv
// heading_pid: heading-hold PID that turns yaw error into differential left/right motor speeds.
// Define HEADING_PID_DTERM_EN to build the derivative path (error history queue + D term).
module heading_pid (
    input  logic               clk,
    input  logic               rst,
    input  logic               moving,
    input  logic signed [11:0] dsrd_hdg,
    input  logic signed [11:0] actl_hdg,
    input  logic               hdg_vld,
    input  logic [9:0]         frwrd,
    output logic signed [10:0] lft_spd,
    output logic signed [10:0] rght_spd,
    output logic               out_vld
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_TERMS = 2'd2;
    localparam logic [1:0] S_SUM   = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               w_clr;
    logic               w_ld_err;
    logic               w_ld_terms;
    logic               w_ld_out;

    logic signed [9:0]  r_err_p0;
    logic signed [15:0] r_integ;
    logic signed [13:0] r_p_p1;
    logic signed [9:0]  r_i_p1;
    logic signed [13:0] r_d_p1;
    logic signed [10:0] r_lft_p2;
    logic signed [10:0] r_rght_p2;
    logic               r_vld_p2;

    logic signed [11:0] w_err;
    logic signed [15:0] w_err_ext;
    logic signed [15:0] w_int_sum;
    logic signed [15:0] w_int_nxt;
    logic               w_int_ovf;
    logic signed [13:0] w_p;
    logic signed [13:0] w_d;
    logic signed [13:0] w_pid;
    logic signed [13:0] w_adj;
    logic signed [13:0] w_lsum;
    logic signed [13:0] w_rsum;

    function automatic logic signed [9:0] sat10(input logic signed [11:0] v);
        if (v > 12'sd511)
            return 10'sd511;
        else if (v < -12'sd512)
            return 10'sh200;
        else
            return v[9:0];
    endfunction

    function automatic logic signed [10:0] sat11(input logic signed [13:0] v);
        if (v > 14'sd1023)
            return 11'sd1023;
        else if (v < -14'sd1024)
            return 11'sh400;
        else
            return v[10:0];
    endfunction

    // Control FSM: dropping moving always wins and returns to IDLE on the next edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!moving) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_WAIT;
                S_WAIT:  w_state_nxt = hdg_vld ? S_TERMS : S_WAIT;
                S_TERMS: w_state_nxt = S_SUM;
                S_SUM:   w_state_nxt = S_WAIT;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_clr      = !moving;
        w_ld_err   = moving && (r_state == S_WAIT) && hdg_vld;
        w_ld_terms = moving && (r_state == S_TERMS);
        w_ld_out   = moving && (r_state == S_SUM);
    end

    // Stage p0: wrapped heading error, saturated to 10 bits
    assign w_err = actl_hdg - dsrd_hdg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_err_p0 <= '0;
        else if (w_ld_err)
            r_err_p0 <= sat10(w_err);
    end

    // Stage p1: P, I (overflow-holding integrator) and D terms
    assign w_err_ext = {{6{r_err_p0[9]}}, r_err_p0};
    assign w_int_sum = r_integ + w_err_ext;
    assign w_int_ovf = (r_integ[15] == w_err_ext[15]) && (w_int_sum[15] != r_integ[15]);
    assign w_int_nxt = w_int_ovf ? r_integ : w_int_sum;
    assign w_p       = $signed({{4{r_err_p0[9]}}, r_err_p0}) * 14'sd5;

`ifdef HEADING_PID_DTERM_EN
    logic signed [9:0]  r_dq0_p1;
    logic signed [9:0]  r_dq1_p1;
    logic signed [10:0] w_ddiff;
    logic signed [6:0]  w_dsat;

    function automatic logic signed [6:0] sat7(input logic signed [10:0] v);
        if (v > 11'sd63)
            return 7'sd63;
        else if (v < -11'sd64)
            return 7'sh40;
        else
            return v[6:0];
    endfunction

    assign w_ddiff = {r_err_p0[9], r_err_p0} - {r_dq1_p1[9], r_dq1_p1};
    assign w_dsat  = sat7(w_ddiff);
    assign w_d     = $signed({{7{w_dsat[6]}}, w_dsat}) * 14'sd6;

    // History survives IDLE; only reset clears it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dq0_p1 <= '0;
            r_dq1_p1 <= '0;
        end else if (w_ld_terms) begin
            r_dq0_p1 <= r_err_p0;
            r_dq1_p1 <= r_dq0_p1;
        end
    end
`else
    assign w_d = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_integ <= '0;
        else if (w_clr)
            r_integ <= '0;
        else if (w_ld_terms)
            r_integ <= w_int_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p_p1 <= '0;
            r_i_p1 <= '0;
            r_d_p1 <= '0;
        end else if (w_ld_terms) begin
            r_p_p1 <= w_p;
            r_i_p1 <= w_int_nxt[15:6];
            r_d_p1 <= w_d;
        end
    end

    // Stage p2: PID sum, differential steering, output saturation
    assign w_pid  = r_p_p1 + $signed({{4{r_i_p1[9]}}, r_i_p1}) + r_d_p1;
    assign w_adj  = w_pid >>> 3;
    assign w_lsum = $signed({4'b0000, frwrd}) + w_adj;
    assign w_rsum = $signed({4'b0000, frwrd}) - w_adj;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lft_p2  <= '0;
            r_rght_p2 <= '0;
            r_vld_p2  <= 1'b0;
        end else if (w_clr) begin
            r_lft_p2  <= '0;
            r_rght_p2 <= '0;
            r_vld_p2  <= 1'b0;
        end else begin
            r_vld_p2 <= w_ld_out;
            if (w_ld_out) begin
                r_lft_p2  <= sat11(w_lsum);
                r_rght_p2 <= sat11(w_rsum);
            end
        end
    end

    assign lft_spd  = r_lft_p2;
    assign rght_spd = r_rght_p2;
    assign out_vld  = r_vld_p2;

endmodule

// File: tb/tb_heading_pid.sv
// tb_heading_pid: directed bench for heading_pid with a transaction-level reference model
// checked every cycle, plus literal expectations for the documented scenarios.
`timescale 1ns/1ps
module tb_heading_pid;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               moving = 1'b0;
    logic signed [11:0] dsrd_hdg = '0;
    logic signed [11:0] actl_hdg = '0;
    logic               hdg_vld = 1'b0;
    logic [9:0]         frwrd = '0;
    logic signed [10:0] lft_spd;
    logic signed [10:0] rght_spd;
    logic               out_vld;

    int n_vec = 0;
    int n_bad = 0;

    heading_pid dut (
        .clk(clk), .rst(rst), .moving(moving),
        .dsrd_hdg(dsrd_hdg), .actl_hdg(actl_hdg), .hdg_vld(hdg_vld),
        .frwrd(frwrd), .lft_spd(lft_spd), .rght_spd(rght_spd), .out_vld(out_vld)
    );

    always #5 clk = ~clk;

    // Reference model: sample accepted -> terms one edge later -> speeds the edge after
    int m_idle = 1, m_ready = 0, m_pend = 0;
    int m_e = 0, m_adj = 0, m_int = 0, m_h0 = 0, m_h1 = 0;
    int m_l = 0, m_r = 0, m_v = 0;

    function automatic int clip(input int v, input int lo, input int hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_idle = 1; m_ready = 0; m_pend = 0;
        m_int = 0; m_h0 = 0; m_h1 = 0;
        m_l = 0; m_r = 0; m_v = 0;
    endtask

    task automatic m_step();
        int e, nint, p, i, d;
        m_v = 0;
        if (!moving) begin
            m_idle = 1; m_ready = 0; m_pend = 0; m_int = 0; m_l = 0; m_r = 0;
        end else if (m_idle) begin
            m_idle = 0; m_ready = 1;
        end else if (m_pend == 2) begin
            nint = m_int + m_e;
            if (nint <= 32767 && nint >= -32768) m_int = nint;
            p = 5 * m_e;
            i = m_int >>> 6;
`ifdef HEADING_PID_DTERM_EN
            d = 6 * clip(m_e - m_h1, -64, 63);
            m_h1 = m_h0;
            m_h0 = m_e;
`else
            d = 0;
`endif
            m_adj = (p + i + d) >>> 3;
            m_pend = 1;
        end else if (m_pend == 1) begin
            m_l = clip(int'(frwrd) + m_adj, -1024, 1023);
            m_r = clip(int'(frwrd) - m_adj, -1024, 1023);
            m_v = 1; m_pend = 0; m_ready = 1;
        end else if (m_ready == 1 && hdg_vld) begin
            e = int'(actl_hdg) - int'(dsrd_hdg);
            e = ((e % 4096) + 4096) % 4096;
            if (e >= 2048) e = e - 4096;
            m_e = clip(e, -512, 511);
            m_pend = 2; m_ready = 0;
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) m_reset();
        else m_step();
    end

    initial forever begin
        @(negedge clk);
        check("out_vld", int'(out_vld), m_v);
        check("lft_spd", int'(lft_spd), m_l);
        check("rght_spd", int'(rght_spd), m_r);
    end

    task automatic pulse(input int d, input int a, input bit extra);
        dsrd_hdg = 12'(d);
        actl_hdg = 12'(a);
        hdg_vld  = 1'b1;
        @(negedge clk);
        if (extra) @(negedge clk);
        hdg_vld = 1'b0;
    endtask

    task automatic wait_out(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            seen = out_vld;
        end
        check(name, int'(seen), 1);
    endtask

    initial begin
        int nv;
        repeat (2) @(negedge clk);
        check("rst_lft", int'(lft_spd), 0);
        check("rst_rght", int'(rght_spd), 0);
        check("rst_vld", int'(out_vld), 0);
        check("rst_state", int'(dut.r_state), 0);
        rst = 1'b0; moving = 1'b1; frwrd = 10'd256;
        @(negedge clk);

        pulse(0, 16, 1'b0);
        wait_out("basic_done");
`ifdef HEADING_PID_DTERM_EN
        check("basic_lft", int'(lft_spd), 278);
        check("basic_rght", int'(rght_spd), 234);
`else
        check("basic_lft", int'(lft_spd), 266);
        check("basic_rght", int'(rght_spd), 246);
`endif

        pulse(2032, -2032, 1'b0);
        check("wrap_err", int'(dut.r_err_p0), 32);
        wait_out("wrap_done");
        pulse(0, 2047, 1'b0);
        check("sat_err", int'(dut.r_err_p0), 511);
        wait_out("sat_done");

        pulse(0, -40, 1'b1);
        nv = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            nv += int'(out_vld);
        end
        check("drop_count", nv, 1);

        pulse(0, 100, 1'b0);
        moving = 1'b0;
        @(negedge clk);
        check("stop_lft", int'(lft_spd), 0);
        check("stop_rght", int'(rght_spd), 0);
        check("stop_vld", int'(out_vld), 0);
        check("stop_int", int'(dut.r_integ), 0);
        check("stop_state", int'(dut.r_state), 0);
        repeat (3) @(negedge clk);

        moving = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 70; n++) begin
            pulse(0, 2047, 1'b0);
            wait_out("clamp_done");
            check("clamp_sign", int'(dut.r_integ[15]), 0);
        end
        check("clamp_int", int'(dut.r_integ), 32704);
        check("clamp_iterm", int'(dut.r_i_p1), 511);
        check("clamp_lft", int'(lft_spd), 639);
        check("clamp_rght", int'(rght_spd), -127);

        pulse(0, 16, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("rstmid_lft", int'(lft_spd), 0);
        check("rstmid_rght", int'(rght_spd), 0);
        check("rstmid_vld", int'(out_vld), 0);
        check("rstmid_state", int'(dut.r_state), 0);
        nv = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            nv += int'(out_vld);
        end
        check("rstmid_nopulse", nv, 0);
        moving = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        moving = 1'b1;
        @(negedge clk);
        pulse(0, 16, 1'b0);
        wait_out("post_rst_done");
`ifdef HEADING_PID_DTERM_EN
        check("post_rst_lft", int'(lft_spd), 278);
`else
        check("post_rst_lft", int'(lft_spd), 266);
`endif
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/heading_pid.md
HEADING_PID -- requirements
Module: heading_pid

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all flops rise-edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port moving, input, 1, high while the platform is commanded to move.
REQ-004 SHALL have port dsrd_hdg, input, 12 signed, desired heading.
REQ-005 SHALL have port actl_hdg, input, 12 signed, actual heading (yaw from inertial interface).
REQ-006 SHALL have port hdg_vld, input, 1, one-cycle pulse when actl_hdg is new.
REQ-007 SHALL have port frwrd, input, 10 unsigned, forward speed.
REQ-008 SHALL have port lft_spd, output, 11 signed, left motor speed.
REQ-009 SHALL have port rght_spd, output, 11 signed, right motor speed.
REQ-010 SHALL have port out_vld, output, 1, one-cycle pulse when speeds update.

Function
REQ-011 SHALL use FSM states IDLE, WAIT, TERMS, SUM.
REQ-012 IDLE SHALL go to WAIT when moving=1; any state SHALL go to IDLE on the next edge when moving=0.
REQ-013 WAIT SHALL go to TERMS on an edge sampling hdg_vld=1 and SHALL register err_reg on that edge.
REQ-014 TERMS SHALL go to SUM unconditionally; SUM SHALL go to WAIT unconditionally.
REQ-015 hdg_vld in IDLE, TERMS or SUM SHALL be ignored, with no queuing.
REQ-016 err SHALL be (actl_hdg - dsrd_hdg) mod 4096 as 12-bit signed, so heading wrap folds naturally.
REQ-017 err_reg SHALL be err saturated to 10-bit signed [-512, 511].
REQ-018 P_term SHALL be err_reg * 5, 14-bit signed.
REQ-019 The integrator SHALL be 16-bit signed and add sign-extended err_reg on the TERMS edge.
REQ-020 On signed overflow (operands same sign, result sign differs) the integrator SHALL hold its old value.
REQ-021 I_term SHALL be integrator_next[15:6], 10-bit signed, using the value including the current sample.
REQ-022 The D queue SHALL be 2 deep, holding the err_reg of the last two accepted samples, and SHALL shift on the TERMS edge.
REQ-023 D_diff SHALL be err_reg minus the oldest queue entry, saturated to 7-bit signed [-64, 63].
REQ-024 D_term SHALL be D_diff * 6, 14-bit signed.
REQ-025 P_term, I_term and D_term SHALL be registered on the TERMS edge.
REQ-026 PID SHALL be the 14-bit signed sum P+I+D, which cannot overflow by range.
REQ-027 adj SHALL be PID >>> 3, an 11-bit signed arithmetic shift.
REQ-028 On the SUM edge, lft_spd SHALL be sat11({0,frwrd} + adj) and rght_spd sat11({0,frwrd} - adj), saturating to [-1024, 1023].
REQ-029 out_vld SHALL be high for the single cycle after the SUM edge, giving latency of 2 edges after the edge sampling hdg_vld.
REQ-030 In IDLE, lft_spd and rght_spd SHALL be 0, the integrator 0, and out_vld 0.
REQ-031 The D queue SHALL keep its contents across IDLE.

Reset
REQ-032 rst=1 SHALL asynchronously force state IDLE, lft_spd=0, rght_spd=0, out_vld=0, integrator=0, queue=0, err_reg=0 and all term registers 0.
REQ-033 rst asserted mid-operation SHALL abort the computation with no out_vld pulse.
REQ-034 The first hdg_vld SHALL be accepted on the first edge after rst falls with moving=1 and the FSM in WAIT.

Configuration
REQ-035 With macro HEADING_PID_DTERM_EN defined, the D queue and D_term SHALL be built as in REQ-022 to REQ-024.
REQ-036 Without HEADING_PID_DTERM_EN, D_term SHALL be constant 0, no queue flops SHALL exist, and latency SHALL be unchanged.

Verification
REQ-037 Reset check: assert rst mid-TERMS -> lft_spd=0, rght_spd=0, out_vld never pulses, FSM in IDLE.
REQ-038 Basic step: moving=1, frwrd=256, dsrd=0, actl=16, one hdg_vld -> after 2 edges, with D: lft=278, rght=234 (P=80, I=0, D=96, adj=22); without D: lft=266, rght=246.
REQ-039 Wrap and saturation: dsrd=2032, actl=-2032 -> err_reg=32; dsrd=0, actl=2047 -> err_reg=511.
REQ-040 Integrator clamp: 70 samples at err_reg=511 -> integrator stops at 32704, I_term=511, never goes negative.
REQ-041 Dropped pulse: hdg_vld re-asserted during TERMS -> exactly one out_vld, no second computation.
REQ-042 Stop: moving=0 the cycle after hdg_vld -> next edge IDLE, speeds 0, integrator 0, no out_vld.
